// File: rtl/ipd_pkg.sv
// Shared definitions for the I-PD sample sequencer: datapath width default,
// FSM state encoding and the signed clamp helper used by ipd_sat.
package ipd_pkg;

   localparam int unsigned ANCHO = 20;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ERR    = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      SUM    = 3'd4,
      UPDATE = 3'd5
   } ipd_state_t;

   // Clamp a signed value into [lo, hi]; operands are widened to 64 bits by callers.
   function automatic longint sat_clamp(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/ipd_sequencer_if.sv
// Bus between the sample sequencer, the ADC sampler, the I-PD term unit and the
// PWM duty generator. master = sequencer side, slave = environment side.
// The setpoint is carried as ref_val because "ref" is a reserved word in SV.
interface ipd_sequencer_if
   import ipd_pkg::*;
#(
   parameter int unsigned ancho = ANCHO
);
   logic                    sample_valid;
   logic signed [ancho-1:0] yk;
   logic signed [ancho-1:0] ref_val;
   logic                    ipd_ready;
   logic signed [ancho-1:0] integral;
   logic signed [ancho-1:0] proporcional;
   logic signed [ancho-1:0] derivada;
   logic                    ready_e;
   logic signed [ancho-1:0] yk_o;
   logic signed [ancho-1:0] yk1_o;
   logic signed [ancho-1:0] i1_o;
   logic signed [ancho-1:0] error_o;
   logic signed [ancho-1:0] u;
   logic                    u_valid;
   logic                    busy;
   logic                    overrun;
   logic                    fault;

   modport master (
      input  sample_valid, yk, ref_val, ipd_ready, integral, proporcional, derivada,
      output ready_e, yk_o, yk1_o, i1_o, error_o, u, u_valid, busy, overrun, fault
   );

   modport slave (
      output sample_valid, yk, ref_val, ipd_ready, integral, proporcional, derivada,
      input  ready_e, yk_o, yk1_o, i1_o, error_o, u, u_valid, busy, overrun, fault
   );
endinterface

// File: rtl/ipd_sat.sv
// Combinational signed clamp from IN_W bits into OUT_W bits with limits [LO, HI].
module ipd_sat
   import ipd_pkg::*;
#(
   parameter int unsigned IN_W  = 21,
   parameter int unsigned OUT_W = 20,
   parameter longint      LO    = -524288,
   parameter longint      HI    = 524287
) (
   input  logic signed [IN_W-1:0]  a,
   output logic signed [OUT_W-1:0] y
);

   // Sign-extend, clamp, then narrow to the output width.
   always_comb begin
      y = OUT_W'(sat_clamp(longint'(a), LO, HI));
   end

endmodule

// File: rtl/ipd_sequencer.sv
// Per-sample controller for the I-PD term unit: forms the saturated error,
// hands the state to the term unit, combines u = I - P - D, clamps u to
// [UMIN, UMAX] and updates yk1/i1.
// Optional feature macro: IPD_ANTIWINDUP_EN (suppresses the i1 update while
// u is saturated in the direction the error is pushing).
module ipd_sequencer
   import ipd_pkg::*;
#(
   parameter int unsigned             ancho   = ANCHO,
   parameter logic signed [ancho-1:0] UMAX    = 20'sd262143,
   parameter logic signed [ancho-1:0] UMIN    = 20'sd0,
   parameter int unsigned             TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   ipd_sequencer_if.master bus
);

   localparam int unsigned CW   = $clog2(TIMEOUT + 1);
   localparam longint      EMAX = (longint'(1) <<< (ancho - 1)) - 1;
   localparam longint      EMIN = -(longint'(1) <<< (ancho - 1));

   ipd_state_t              state_q, state_d;
   logic signed [ancho-1:0] yk_q, yk_d, ref_q, ref_d, error_q, error_d;
   logic signed [ancho-1:0] i_q, i_d, p_q, p_d, dv_q, dv_d;
   logic signed [ancho-1:0] u_q, u_d, yk1_q, yk1_d, i1_q, i1_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    u_valid_q, u_valid_d, overrun_q, overrun_d;
   logic                    fault_q, fault_d, hold_q, hold_d;
   logic signed [ancho:0]   err_raw;
   logic signed [ancho+1:0] s_raw;
   logic signed [ancho-1:0] err_sat, u_sat;

   // Full-precision error and term sum, widened so neither can wrap.
   always_comb begin
      err_raw = {ref_q[ancho-1], ref_q} - {yk_q[ancho-1], yk_q};
      s_raw   = {{2{i_q[ancho-1]}}, i_q} - {{2{p_q[ancho-1]}}, p_q}
              - {{2{dv_q[ancho-1]}}, dv_q};
   end

   ipd_sat #(.IN_W(ancho + 1), .OUT_W(ancho), .LO(EMIN), .HI(EMAX))
      u_err_sat (.a(err_raw), .y(err_sat));

   ipd_sat #(.IN_W(ancho + 2), .OUT_W(ancho), .LO(longint'(UMIN)), .HI(longint'(UMAX)))
      u_out_sat (.a(s_raw), .y(u_sat));

   // State and datapath registers; synchronous reset clears everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         yk_q      <= '0;
         ref_q     <= '0;
         error_q   <= '0;
         i_q       <= '0;
         p_q       <= '0;
         dv_q      <= '0;
         u_q       <= '0;
         yk1_q     <= '0;
         i1_q      <= '0;
         cnt_q     <= '0;
         u_valid_q <= 1'b0;
         overrun_q <= 1'b0;
         fault_q   <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         yk_q      <= yk_d;
         ref_q     <= ref_d;
         error_q   <= error_d;
         i_q       <= i_d;
         p_q       <= p_d;
         dv_q      <= dv_d;
         u_q       <= u_d;
         yk1_q     <= yk1_d;
         i1_q      <= i1_d;
         cnt_q     <= cnt_d;
         u_valid_q <= u_valid_d;
         overrun_q <= overrun_d;
         fault_q   <= fault_d;
         hold_q    <= hold_d;
      end
   end

   // Next-state and register-update logic for the per-sample sequence.
   always_comb begin
      state_d   = state_q;
      yk_d      = yk_q;
      ref_d     = ref_q;
      error_d   = error_q;
      i_d       = i_q;
      p_d       = p_q;
      dv_d      = dv_q;
      u_d       = u_q;
      yk1_d     = yk1_q;
      i1_d      = i1_q;
      cnt_d     = cnt_q;
      u_valid_d = 1'b0;
      overrun_d = overrun_q;
      fault_d   = fault_q;
      hold_d    = hold_q;

      if (bus.sample_valid && (state_q != IDLE)) overrun_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (bus.sample_valid) begin
               yk_d    = bus.yk;
               ref_d   = bus.ref_val;
               state_d = ERR;
            end
         end
         ERR: begin
            error_d = err_sat;
            state_d = START;
         end
         START: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.ipd_ready) begin
               i_d     = bus.integral;
               p_d     = bus.proporcional;
               dv_d    = bus.derivada;
               state_d = SUM;
            end else if (cnt_q == CW'(TIMEOUT)) begin
               fault_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SUM: begin
            u_d = u_sat;
`ifdef IPD_ANTIWINDUP_EN
            hold_d = ((longint'(s_raw) > longint'(UMAX)) && !error_q[ancho-1] && (error_q != '0))
                  || ((longint'(s_raw) < longint'(UMIN)) && error_q[ancho-1]);
`else
            hold_d = 1'b0;
`endif
            state_d = UPDATE;
         end
         UPDATE: begin
            yk1_d = yk_q;
            if (!hold_q) i1_d = i_q;
            u_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output drive: start pulse and busy decode from state, the rest from registers.
   always_comb begin
      bus.ready_e = (state_q == START);
      bus.busy    = (state_q != IDLE);
      bus.yk_o    = yk_q;
      bus.yk1_o   = yk1_q;
      bus.i1_o    = i1_q;
      bus.error_o = error_q;
      bus.u       = u_q;
      bus.u_valid = u_valid_q;
      bus.overrun = overrun_q;
      bus.fault   = fault_q;
   end

endmodule
